// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared state, size encodings and defaults for mem_arbiter
//
// Contents:
//   state_t             FSM state encoding
//   SZ_B / SZ_H / SZ_W  access size encodings (byte, half, word)
//   STARVE_MAX_DEFAULT  default data-grant budget while a fetch waits
package mem_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_I  = 3'd1,
        REQ_D  = 3'd2,
        WAIT_I = 3'd3,
        WAIT_D = 3'd4
    } state_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam int STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, data and shared memory port bundle for mem_arbiter
//
// Signals:
//   i_*    instruction-fetch request / accept / response
//   d_*    data load/store request / accept / response
//   flush  control-flow redirect (fetch side only)
//   m_*    shared memory port request, grant and response
//   err    sticky stray-response flag
// Modports:
//   slave   the arbiter
//   master  the surrounding core and memory
interface mem_arbiter_if;

    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ready;
    logic        i_rvalid;
    logic [31:0] i_rdata;

    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    logic        flush;

    logic        m_req;
    logic        m_we;
    logic [1:0]  m_size;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_gnt;
    logic        m_rvalid;
    logic [31:0] m_rdata;

    logic        err;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata, flush,
               m_gnt, m_rvalid, m_rdata,
        output i_ready, i_rvalid, i_rdata, d_ready, d_rvalid, d_rdata,
               m_req, m_we, m_size, m_addr, m_wdata, err
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata, flush,
               m_gnt, m_rvalid, m_rdata,
        input  i_ready, i_rvalid, i_rdata, d_ready, d_rvalid, d_rdata,
               m_req, m_we, m_size, m_addr, m_wdata, err
    );

endinterface

// File: rtl/mem_arbiter_arb_prio.sv
// rtl/mem_arbiter_arb_prio.sv - data-first arbitration with fetch starvation guard
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   arb_en            arbitration slot (FSM is idle)
//   i_req, d_req      pending fetch / data requests
//   grant_i, grant_d  one-hot grant, only while arb_en
module arb_prio
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic arb_en,
    input  logic i_req,
    input  logic d_req,
    output logic grant_i,
    output logic grant_d
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    logic [CW-1:0] cnt;
    logic          starved;

    // Once the fetch has watched STARVE_MAX data grants go by it takes the next slot.
    assign starved = i_req && (cnt == CNT_MAX);
    assign grant_d = arb_en && d_req && !starved;
    assign grant_i = arb_en && i_req && !grant_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!i_req || grant_i) begin
            cnt <= '0;
        end else if (grant_d && cnt != CNT_MAX) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter onto a single-outstanding shared memory port
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   mem_arbiter_if.slave: fetch side, data side, flush, memory port, err
// Parameter:
//   STARVE_MAX  consecutive data grants tolerated while a fetch waits
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    state_t state;
    logic   drop;
    logic   grant_i;
    logic   grant_d;
    logic   stray;

    arb_prio #(.STARVE_MAX(STARVE_MAX)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .arb_en  (state == IDLE),
        .i_req   (bus.i_req),
        .d_req   (bus.d_req),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

    assign bus.i_ready  = (state == REQ_I) && bus.m_gnt;
    assign bus.d_ready  = (state == REQ_D) && bus.m_gnt;
    // A flush in the same cycle as the response discards it just like a flagged one.
    assign bus.i_rvalid = (state == WAIT_I) && bus.m_rvalid && !drop && !bus.flush;
    assign bus.d_rvalid = (state == WAIT_D) && bus.m_rvalid;
    assign bus.i_rdata  = bus.m_rdata;
    assign bus.d_rdata  = bus.m_rdata;

    // A response is only legal while waiting; a grant+rvalid collision in REQ_x counts as stray.
    assign stray = bus.m_rvalid && (state == IDLE || state == REQ_I || state == REQ_D);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            bus.m_req   <= 1'b0;
            bus.m_we    <= 1'b0;
            bus.m_size  <= SZ_B;
            bus.m_addr  <= '0;
            bus.m_wdata <= '0;
            drop        <= 1'b0;
            bus.err     <= 1'b0;
        end else begin
            if (stray) begin
                bus.err <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (grant_d) begin
                        bus.m_req   <= 1'b1;
                        bus.m_we    <= bus.d_we;
                        bus.m_size  <= bus.d_size;
                        bus.m_addr  <= bus.d_addr;
                        bus.m_wdata <= bus.d_wdata;
                        state       <= REQ_D;
                    end else if (grant_i) begin
                        bus.m_req   <= 1'b1;
                        bus.m_we    <= 1'b0;
                        bus.m_size  <= SZ_W;
                        bus.m_addr  <= bus.i_addr;
                        bus.m_wdata <= '0;
                        state       <= REQ_I;
                    end
                end
                REQ_I, REQ_D: begin
                    // The request is never withdrawn; flush only marks the response for discard.
                    if (state == REQ_I && bus.flush) begin
                        drop <= 1'b1;
                    end
                    if (bus.m_gnt) begin
                        bus.m_req <= 1'b0;
                        state     <= (state == REQ_I) ? WAIT_I : WAIT_D;
                    end
                end
                WAIT_I: begin
                    if (bus.m_rvalid) begin
                        drop  <= 1'b0;
                        state <= IDLE;
                    end else if (bus.flush) begin
                        drop <= 1'b1;
                    end
                end
                WAIT_D: begin
                    if (bus.m_rvalid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    typedef struct {
        logic        is_d;
        logic [31:0] addr;
        logic        we;
        logic [1:0]  size;
        logic [31:0] wdata;
    } gnt_t;

    typedef struct {
        logic        is_d;
        logic        chk_data;
        logic [31:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    gnt_t        exp_gnt_q[$];
    rsp_t        exp_rsp_q[$];
    logic [31:0] mem_data_q[$];

    int  checks = 0;
    int  passes = 0;
    int  i_ready_cnt = 0;
    int  i_rvalid_cnt = 0;
    int  d_rvalid_cnt = 0;
    int  stable_cnt = 0;
    time last_i_gnt_t = 0;
    time last_d_rvalid_t = 0;

    logic mem_en = 1'b0;
    int   gnt_delay = 1;
    int   rv_delay = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, req);
    endtask

    task automatic exp_i(input logic [31:0] addr, input logic [31:0] rdata);
        exp_gnt_q.push_back('{1'b0, addr, 1'b0, SZ_W, 32'h0});
        mem_data_q.push_back(rdata);
        exp_rsp_q.push_back('{1'b0, 1'b1, rdata});
    endtask

    task automatic exp_d(input logic we, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata);
        exp_gnt_q.push_back('{1'b1, addr, we, size, wdata});
        mem_data_q.push_back(rdata);
        exp_rsp_q.push_back('{1'b1, !we, rdata});
    endtask

    task automatic drive_i(input logic [31:0] addr);
        int n = 0;
        bus.i_req  = 1'b1;
        bus.i_addr = addr;
        do begin @(negedge clk); n++; end while (!bus.i_ready && n < 200);
        if (!bus.i_ready) chk("i_ready_timeout", 32'(n), 32'(0));
        @(posedge clk); #1;
        bus.i_req = 1'b0;
    endtask

    task automatic drive_d(input logic we, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata);
        int n = 0;
        bus.d_req   = 1'b1;
        bus.d_we    = we;
        bus.d_size  = size;
        bus.d_addr  = addr;
        bus.d_wdata = wdata;
        do begin @(negedge clk); n++; end while (!bus.d_ready && n < 200);
        if (!bus.d_ready) chk("d_ready_timeout", 32'(n), 32'(0));
        @(posedge clk); #1;
        bus.d_req = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_rsp_q.size() != 0 || exp_gnt_q.size() != 0 || dut.state != IDLE) && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk({name, "_done"}, 32'(n < 300), 32'(1));
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_m_req"},   32'(bus.m_req),   32'(0));
        chk({name, "_m_we"},    32'(bus.m_we),    32'(0));
        chk({name, "_m_size"},  32'(bus.m_size),  32'(0));
        chk({name, "_m_addr"},  bus.m_addr,       32'(0));
        chk({name, "_m_wdata"}, bus.m_wdata,      32'(0));
        chk({name, "_err"},     32'(bus.err),     32'(0));
        chk({name, "_ready"},   32'({bus.i_ready, bus.d_ready}),   32'(0));
        chk({name, "_rvalid"},  32'({bus.i_rvalid, bus.d_rvalid}), 32'(0));
        chk({name, "_state"},   32'(dut.state),   32'(IDLE));
    endtask

    // Memory model: grant after gnt_delay cycles, respond rv_delay cycles after grant.
    initial begin
        bus.m_gnt    = 1'b0;
        bus.m_rvalid = 1'b0;
        bus.m_rdata  = '0;
        forever begin
            @(posedge clk); #1;
            if (mem_en && bus.m_req) begin
                for (int k = 0; k < gnt_delay; k++) begin @(posedge clk); #1; end
                bus.m_gnt = 1'b1;
                @(posedge clk); #1;
                bus.m_gnt = 1'b0;
                for (int k = 0; k < rv_delay - 1; k++) begin @(posedge clk); #1; end
                bus.m_rvalid = 1'b1;
                bus.m_rdata  = (mem_data_q.size() != 0) ? mem_data_q.pop_front() : 32'h0;
                @(posedge clk); #1;
                bus.m_rvalid = 1'b0;
            end
        end
    end

    // Grant and response monitor.
    initial begin
        gnt_t g;
        rsp_t r;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rvalid_exclusive", 32'(bus.i_rvalid && bus.d_rvalid), 32'(0));
                if (bus.i_ready) begin i_ready_cnt++; last_i_gnt_t = $time; end
                if (bus.i_rvalid) i_rvalid_cnt++;
                if (bus.d_rvalid) begin d_rvalid_cnt++; last_d_rvalid_t = $time; end
                if (bus.i_ready || bus.d_ready) begin
                    if (exp_gnt_q.size() == 0) begin
                        chk("unexpected_grant", 32'({bus.i_ready, bus.d_ready}), 32'(0));
                    end else begin
                        g = exp_gnt_q.pop_front();
                        chk("gnt_side", 32'({bus.i_ready, bus.d_ready}), g.is_d ? 32'(1) : 32'(2));
                        chk("gnt_m_req", 32'(bus.m_req), 32'(1));
                        chk("gnt_addr", bus.m_addr, g.addr);
                        chk("gnt_we", 32'(bus.m_we), 32'(g.we));
                        if (g.is_d) begin
                            chk("gnt_size", 32'(bus.m_size), 32'(g.size));
                            if (g.we) chk("gnt_wdata", bus.m_wdata, g.wdata);
                        end
                    end
                end
                if (bus.i_rvalid || bus.d_rvalid) begin
                    if (exp_rsp_q.size() == 0) begin
                        chk("unexpected_resp", 32'({bus.i_rvalid, bus.d_rvalid}), 32'(0));
                    end else begin
                        r = exp_rsp_q.pop_front();
                        chk("rsp_side", 32'({bus.i_rvalid, bus.d_rvalid}), r.is_d ? 32'(1) : 32'(2));
                        if (r.chk_data) chk("rsp_data", r.is_d ? bus.d_rdata : bus.i_rdata, r.data);
                    end
                end
            end
        end
    end

    // m_* must hold while a request waits for its grant.
    initial begin
        logic        p_req = 1'b0;
        logic        p_gnt = 1'b0;
        logic [66:0] p_fields = '0;
        forever begin
            @(negedge clk);
            if (rst && bus.m_req && p_req && !p_gnt) begin
                stable_cnt++;
                chk("hold_fields", 32'({bus.m_we, bus.m_size, bus.m_addr, bus.m_wdata} == p_fields), 32'(1));
                chk("ready_without_gnt", 32'((bus.i_ready || bus.d_ready) && !bus.m_gnt), 32'(0));
            end
            p_req    = bus.m_req;
            p_gnt    = bus.m_gnt;
            p_fields = {bus.m_we, bus.m_size, bus.m_addr, bus.m_wdata};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int i0, d0, r0, s0;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_size = SZ_B; bus.d_addr = '0; bus.d_wdata = '0;
        bus.flush = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst    = 1'b1;
        mem_en = 1'b1;
        @(posedge clk); #1;

        // Single fetch.
        gnt_delay = 1; rv_delay = 2;
        i0 = i_ready_cnt; d0 = d_rvalid_cnt;
        exp_i(32'h100, 32'h0000_0013);
        drive_i(32'h100);
        drain("fetch");
        chk("fetch_i_ready_pulses", 32'(i_ready_cnt - i0), 32'(1));
        chk("fetch_no_d_rvalid", 32'(d_rvalid_cnt - d0), 32'(0));

        // Simultaneous store and fetch: data first.
        exp_d(1'b1, SZ_W, 32'h200, 32'hDEAD_BEEF, 32'h0);
        exp_i(32'h104, 32'h0000_0011);
        fork
            drive_i(32'h104);
            drive_d(1'b1, SZ_W, 32'h200, 32'hDEAD_BEEF);
        join
        drain("prio");
        chk("fetch_after_store", 32'(last_i_gnt_t > last_d_rvalid_t), 32'(1));

        // Starvation guard: D x4, I, D x4, I, D.
        gnt_delay = 0; rv_delay = 1;
        for (int k = 0; k < 4; k++) exp_d(1'b0, SZ_W, 32'h300 + 32'(4 * k), 32'h0, 32'hA000 + 32'(k));
        exp_i(32'h400, 32'hB000);
        for (int k = 4; k < 8; k++) exp_d(1'b0, SZ_W, 32'h300 + 32'(4 * k), 32'h0, 32'hA000 + 32'(k));
        exp_i(32'h404, 32'hB001);
        exp_d(1'b0, SZ_W, 32'h320, 32'h0, 32'hA008);
        fork
            begin for (int k = 0; k < 9; k++) drive_d(1'b0, SZ_W, 32'h300 + 32'(4 * k), 32'h0); end
            begin drive_i(32'h400); drive_i(32'h404); end
        join
        drain("starve");

        // Flush while waiting for the fetch response.
        gnt_delay = 1; rv_delay = 3;
        r0 = i_rvalid_cnt;
        exp_gnt_q.push_back('{1'b0, 32'h500, 1'b0, SZ_W, 32'h0});
        mem_data_q.push_back(32'hCAFE_F00D);
        drive_i(32'h500);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        drain("flush");
        chk("flush_dropped", 32'(i_rvalid_cnt - r0), 32'(0));
        exp_i(32'h504, 32'h0000_0055);
        drive_i(32'h504);
        drain("after_flush");
        chk("after_flush_rvalid", 32'(i_rvalid_cnt - r0), 32'(1));

        // Long grant stall on a half-word store.
        gnt_delay = 10; rv_delay = 1;
        s0 = stable_cnt;
        exp_d(1'b1, SZ_H, 32'h600, 32'h1234_5678, 32'h0);
        drive_d(1'b1, SZ_H, 32'h600, 32'h1234_5678);
        drain("stall");
        chk("stall_hold_cycles", 32'(stable_cnt - s0 >= 10), 32'(1));
        chk("err_clean", 32'(bus.err), 32'(0));

        // Reset during WAIT_D, then a stray response.
        mem_en = 1'b0;
        d0 = d_rvalid_cnt;
        exp_gnt_q.push_back('{1'b1, 32'h700, 1'b0, SZ_W, 32'h0});
        fork
            drive_d(1'b0, SZ_W, 32'h700, 32'h0);
            begin
                int n = 0;
                do begin @(negedge clk); n++; end while (!bus.m_req && n < 50);
                @(posedge clk); #1;
                bus.m_gnt = 1'b1;
                @(posedge clk); #1;
                bus.m_gnt = 1'b0;
            end
        join
        @(negedge clk);
        chk("pre_reset_wait_d", 32'(dut.state), 32'(WAIT_D));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        bus.m_rvalid = 1'b1;
        bus.m_rdata  = 32'h0000_0BAD;
        @(negedge clk);
        chk("stray_no_d_rvalid", 32'(bus.d_rvalid), 32'(0));
        @(posedge clk); #1;
        bus.m_rvalid = 1'b0;
        @(negedge clk);
        chk("stray_err", 32'(bus.err), 32'(1));
        chk("stray_d_rvalid_total", 32'(d_rvalid_cnt - d0), 32'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
